// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer pixel sink.
//   - FSM state encoding of the sink (IDLE / WRITE / CLEAR)
//   - RGB333 pixel width and framebuffer address width
//   - default framebuffer geometry (160 x 120)
//   - helper that truncates RGB888 to RGB333
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_W_DEF = 160;
   localparam int FB_H_DEF = 120;
   localparam int RGB_W    = 9;
   localparam int ADDR_W   = 15;
   localparam int ENTRY_W  = ADDR_W + RGB_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2
   } sink_state_t;

   // Keep the top three bits of each channel; no rounding.
   function automatic logic [RGB_W-1:0] rgb888_to_333(input logic [23:0] rgb);
      return {rgb[23:21], rgb[15:13], rgb[7:5]};
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous show-ahead FIFO holding {address, colour} pixel entries.
// The head entry is visible on pop_data whenever empty=0; pop consumes it.
// A push while full is accepted only if a pop happens on the same edge.
// Ports:
//   clk       in   clock, rising edge
//   resetn    in   asynchronous active-low reset (empties the queue)
//   push      in   write request
//   push_data in   entry to write
//   pop       in   consume head entry
//   pop_data  out  head entry (valid when empty=0)
//   full      out  queue holds DEPTH entries
//   empty     out  queue holds no entries
// -----------------------------------------------------------------------------
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == FULL_COUNT);
   assign do_pop   = pop && !empty;
   // A simultaneous pop frees a slot, so a push into a full queue still lands.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr_reg];

   // Storage carries no reset: contents are only meaningful behind count_reg.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fb_pixel_sink.sv
// -----------------------------------------------------------------------------
// fb_pixel_sink
// Accepts pixels from a shared draw bus, converts them to RGB333 framebuffer
// words and writes them out through a ready/hold handshake. Also performs a
// full-screen fill on request once queued pixels have drained.
// Ports:
//   clk          in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   draw_enable  in   pixel strobe, one pixel per high cycle
//   x_in, y_in   in   pixel column / row
//   rgb_in       in   RGB888 colour
//   clear_req    in   single-cycle fill request
//   clear_color  in   RGB333 fill colour, sampled with clear_req
//   fb_ready     in   framebuffer accepts the presented write this cycle
//   fb_addr      out  framebuffer word address
//   fb_data      out  RGB333 pixel colour
//   fb_we        out  write request, held until accepted
//   busy         out  queue non-empty, write pending, or clear pending/active
//   clear_done   out  one-cycle pulse after the last fill write retires
//   overflow     out  sticky: a pixel was lost to a full queue
//   drop_count   out  saturating count of off-screen pixels
// -----------------------------------------------------------------------------
module fb_pixel_sink
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FB_W       = FB_W_DEF,
   parameter int FB_H       = FB_H_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              draw_enable,
   input  logic [7:0]        x_in,
   input  logic [7:0]        y_in,
   input  logic [23:0]       rgb_in,
   input  logic              clear_req,
   input  logic [RGB_W-1:0]  clear_color,
   input  logic              fb_ready,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [RGB_W-1:0]  fb_data,
   output logic              fb_we,
   output logic              busy,
   output logic              clear_done,
   output logic              overflow,
   output logic [7:0]        drop_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

   sink_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] fb_addr_reg, addr_next;
   logic [RGB_W-1:0]  fb_data_reg, data_next;
   logic              fb_we_reg, we_next;
   logic              clear_pending_reg, clear_pending_next;
   logic [RGB_W-1:0]  clear_color_reg, clear_color_next;
   logic              clear_done_reg, clear_done_next;
   logic              overflow_reg;
   logic [7:0]        drop_count_reg;

   logic [ADDR_W-1:0]  pix_addr;
   logic               bus_parity;
   logic               bus_known;
   logic               on_screen;
   logic               draw_push;
   logic               draw_drop;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;
   logic [ADDR_W-1:0]  head_addr;
   logic [RGB_W-1:0]   head_data;

   // An undriven bus (X/Z on any pixel field) turns the reduction XOR into X,
   // which fails both identity tests. Two-state tools and synthesis see a
   // constant 1 here, so no hardware results from it.
   assign bus_parity = ^{x_in, y_in, rgb_in};
   assign bus_known  = (bus_parity === 1'b0) || (bus_parity === 1'b1);

   assign on_screen  = (32'(x_in) < FB_W) && (32'(y_in) < FB_H);
   assign draw_push  = draw_enable && bus_known && on_screen;
   assign draw_drop  = draw_enable && bus_known && !on_screen;

   // Row-major address; the default 160-wide screen uses y*128 + y*32.
   generate
      if (FB_W == 160) begin : g_addr_shift
         assign pix_addr = (ADDR_W'(y_in) << 7) + (ADDR_W'(y_in) << 5) + ADDR_W'(x_in);
      end else begin : g_addr_mul
         assign pix_addr = ADDR_W'(32'(y_in) * FB_W + 32'(x_in));
      end
   endgenerate

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (draw_push),
      .push_data ({pix_addr, rgb888_to_333(rgb_in)}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_addr = fifo_head[ENTRY_W-1:RGB_W];
   assign head_data = fifo_head[RGB_W-1:0];

   // FSM state and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg         <= IDLE;
         fb_addr_reg       <= '0;
         fb_data_reg       <= '0;
         fb_we_reg         <= 1'b0;
         clear_pending_reg <= 1'b0;
         clear_color_reg   <= '0;
         clear_done_reg    <= 1'b0;
      end else begin
         state_reg         <= state_next;
         fb_addr_reg       <= addr_next;
         fb_data_reg       <= data_next;
         fb_we_reg         <= we_next;
         clear_pending_reg <= clear_pending_next;
         clear_color_reg   <= clear_color_next;
         clear_done_reg    <= clear_done_next;
      end
   end

   // FSM next-state and output logic
   always_comb begin
      state_next         = state_reg;
      addr_next          = fb_addr_reg;
      data_next          = fb_data_reg;
      we_next            = fb_we_reg;
      clear_pending_next = clear_pending_reg;
      clear_color_next   = clear_color_reg;
      clear_done_next    = 1'b0;
      fifo_pop           = 1'b0;

      case (state_reg)
         IDLE: begin
            // Queued pixels take priority so a pending fill never overtakes them.
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               addr_next  = head_addr;
               data_next  = head_data;
               we_next    = 1'b1;
               state_next = WRITE;
            end else if (clear_pending_reg) begin
               clear_pending_next = 1'b0;
               addr_next          = '0;
               data_next          = clear_color_reg;
               we_next            = 1'b1;
               state_next         = CLEAR;
            end
         end
         WRITE: begin
            if (fb_ready) begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  addr_next = head_addr;
                  data_next = head_data;
               end else begin
                  we_next    = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         CLEAR: begin
            if (fb_ready) begin
               if (fb_addr_reg == LAST_ADDR) begin
                  we_next         = 1'b0;
                  clear_done_next = 1'b1;
                  state_next      = IDLE;
               end else begin
                  addr_next = fb_addr_reg + 1'b1;
               end
            end
         end
         default: begin
            we_next    = 1'b0;
            state_next = IDLE;
         end
      endcase

      // Only one fill can be outstanding; later requests are dropped.
      if (clear_req && !clear_pending_reg && (state_reg != CLEAR)) begin
         clear_pending_next = 1'b1;
         clear_color_next   = clear_color;
      end
   end

   // Sticky overflow and saturating off-screen counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow_reg   <= 1'b0;
         drop_count_reg <= '0;
      end else begin
         if (draw_push && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
         end
         if (draw_drop && (drop_count_reg != 8'hFF)) begin
            drop_count_reg <= drop_count_reg + 8'd1;
         end
      end
   end

   assign fb_addr    = fb_addr_reg;
   assign fb_data    = fb_data_reg;
   assign fb_we      = fb_we_reg;
   assign clear_done = clear_done_reg;
   assign overflow   = overflow_reg;
   assign drop_count = drop_count_reg;
   assign busy       = !fifo_empty || fb_we_reg || clear_pending_reg || (state_reg == CLEAR);

endmodule

// File: tb/tb_fb_pixel_sink.sv
// -----------------------------------------------------------------------------
// tb_fb_pixel_sink
// Directed test bench for fb_pixel_sink with hand-computed expectations.
// Retired framebuffer writes are captured into wr_q as {addr, data}.
// -----------------------------------------------------------------------------
module tb_fb_pixel_sink;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        draw_enable = 1'b0;
   logic [7:0]  x_in = '0;
   logic [7:0]  y_in = '0;
   logic [23:0] rgb_in = '0;
   logic        clear_req = 1'b0;
   logic [8:0]  clear_color = '0;
   logic        fb_ready = 1'b0;
   logic [14:0] fb_addr;
   logic [8:0]  fb_data;
   logic        fb_we;
   logic        busy;
   logic        clear_done;
   logic        overflow;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;
   logic [23:0] wr_q[$];
   int done_pulses = 0;

   fb_pixel_sink dut (
      .clk         (clk),
      .resetn      (resetn),
      .draw_enable (draw_enable),
      .x_in        (x_in),
      .y_in        (y_in),
      .rgb_in      (rgb_in),
      .clear_req   (clear_req),
      .clear_color (clear_color),
      .fb_ready    (fb_ready),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .fb_we       (fb_we),
      .busy        (busy),
      .clear_done  (clear_done),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   // A write presented with fb_ready high at the falling edge retires on the
   // following rising edge.
   always @(negedge clk) begin
      if (fb_we && fb_ready) wr_q.push_back({fb_addr, fb_data});
      if (clear_done) done_pulses++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      draw_enable = 1'b1; x_in = 8'd1; y_in = 8'd1; rgb_in = 24'hFFFFFF;
      fb_ready = 1'b1;
      repeat (3) tick();
      draw_enable = 1'b0;
      checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", fb_we); end
      checks++; if (fb_addr !== 15'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", fb_addr); end
      checks++; if (fb_data !== 9'd0) begin errors++; $display("FAIL reset_data got %h want 0", fb_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got %0b want 0", clear_done); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
      resetn = 1'b1;
      fb_ready = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_single();
      wr_q.delete();
      fb_ready = 1'b1;
      draw_enable = 1'b1; x_in = 8'd5; y_in = 8'd3; rgb_in = 24'hFFFFFF;
      tick();                                   // edge N: pushed
      draw_enable = 1'b0;
      checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_n got %0b want 0", fb_we); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
      tick();                                   // edge N+1: presented
      checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL single_we_n1 got %0b want 1", fb_we); end
      checks++; if (fb_addr !== 15'd485) begin errors++; $display("FAIL single_addr got %0d want 485", fb_addr); end
      checks++; if (fb_data !== 9'h1FF) begin errors++; $display("FAIL single_data got %h want 1ff", fb_data); end
      tick();                                   // edge N+2: retired
      checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_n2 got %0b want 0", fb_we); end
      tick();
      checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", wr_q.size()); end
      $display("test_single writes=%0d", wr_q.size());
   endtask

   task automatic test_edge_pixel();
      // Bottom-right corner; RGB A5/5A/C3 truncates to 101/010/110.
      wr_q.delete();
      fb_ready = 1'b1;
      draw_enable = 1'b1; x_in = 8'd159; y_in = 8'd119; rgb_in = 24'hA55AC3;
      tick();
      draw_enable = 1'b0;
      repeat (3) tick();
      checks++;
      if (wr_q.size() !== 1 || wr_q[0] !== {15'd19199, 9'h156}) begin
         errors++;
         $display("FAIL edge_pixel got n=%0d first=%h want n=1 %h", wr_q.size(),
                  (wr_q.size() > 0) ? wr_q[0] : 24'h0, {15'd19199, 9'h156});
      end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL edge_drop got %0d want 0", drop_count); end
      $display("test_edge_pixel writes=%0d", wr_q.size());
   endtask

   task automatic test_stall();
      logic [7:0]  xs[4] = '{8'd0, 8'd1, 8'd159, 8'd0};
      logic [7:0]  ys[4] = '{8'd0, 8'd2, 8'd0, 8'd119};
      logic [23:0] cs[4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080};
      logic [23:0] exp_w[4] = '{{15'd0, 9'h1C0}, {15'd321, 9'h038},
                                {15'd159, 9'h007}, {15'd19040, 9'h124}};
      wr_q.delete();
      fb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         draw_enable = 1'b1; x_in = xs[i]; y_in = ys[i]; rgb_in = cs[i];
         tick();
      end
      draw_enable = 1'b0;
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (fb_we !== 1'b1 || fb_addr !== 15'd0 || fb_data !== 9'h1C0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got we=%0b addr=%0d data=%h want we=1 addr=0 data=1c0",
                     c, fb_we, fb_addr, fb_data);
         end
         tick();
      end
      fb_ready = 1'b1;
      repeat (4) tick();
      checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL stall_drain_we got %0b want 0", fb_we); end
      tick();
      checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL stall_count got %0d want 4", wr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < wr_q.size()) begin
            checks++;
            if (wr_q[i] !== exp_w[i]) begin
               errors++;
               $display("FAIL stall_write[%0d] got %h want %h", i, wr_q[i], exp_w[i]);
            end
         end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow got %0b want 0", overflow); end
      $display("test_stall writes=%0d", wr_q.size());
   endtask

   task automatic test_overflow();
      // Blocker pixel (10,10) = addr 1610, 0x202020 -> 0x049 sits in the
      // output stage; of the six pixels that follow, four fit the queue.
      logic [23:0] exp_w[5] = '{{15'd1610, 9'h049}, {15'd160, 9'h000}, {15'd161, 9'h040},
                                {15'd162, 9'h080}, {15'd163, 9'h0C0}};
      logic [7:0] reds[6] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0};
      wr_q.delete();
      fb_ready = 1'b0;
      draw_enable = 1'b1; x_in = 8'd10; y_in = 8'd10; rgb_in = 24'h202020;
      tick();
      draw_enable = 1'b0;
      tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0b want 0", overflow); end
      for (int i = 0; i < 6; i++) begin
         draw_enable = 1'b1; x_in = 8'(i); y_in = 8'd1; rgb_in = {reds[i], 16'h0000};
         tick();
      end
      draw_enable = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
      fb_ready = 1'b1;
      repeat (8) tick();
      checks++; if (wr_q.size() !== 5) begin errors++; $display("FAIL ovf_count got %0d want 5", wr_q.size()); end
      for (int i = 0; i < 5; i++) begin
         if (i < wr_q.size()) begin
            checks++;
            if (wr_q[i] !== exp_w[i]) begin
               errors++;
               $display("FAIL ovf_write[%0d] got %h want %h", i, wr_q[i], exp_w[i]);
            end
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %0b want 0", busy); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
      $display("test_overflow writes=%0d", wr_q.size());
   endtask

   task automatic test_offscreen();
      wr_q.delete();
      fb_ready = 1'b1;
      draw_enable = 1'b1; x_in = 8'd160; y_in = 8'd0; rgb_in = 24'hFFFFFF;
      tick();
      x_in = 8'd0; y_in = 8'd120;
      tick();
      draw_enable = 1'b0;
      repeat (3) tick();
      checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL offs_writes got %0d want 0", wr_q.size()); end
      checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL offs_drop2 got %0d want 2", drop_count); end
      draw_enable = 1'b1; x_in = 8'd255; y_in = 8'd255;
      repeat (300) tick();
      draw_enable = 1'b0;
      tick();
      checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL offs_sat got %0d want 255", drop_count); end
      checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL offs_writes2 got %0d want 0", wr_q.size()); end
      $display("test_offscreen drop_count=%0d", drop_count);
   endtask

   task automatic test_clear();
      int bad;
      int first_bad;
      logic done_seen;
      wr_q.delete();
      done_pulses = 0;
      fb_ready = 1'b0;
      draw_enable = 1'b1; x_in = 8'd7; y_in = 8'd7; rgb_in = 24'hFFFFFF;   // 1127, 1ff
      tick();
      x_in = 8'd8; y_in = 8'd8; rgb_in = 24'h000000;                      // 1288, 000
      tick();
      draw_enable = 1'b0;
      clear_req = 1'b1; clear_color = 9'h049;
      tick();
      clear_req = 1'b0; clear_color = 9'h000;
      fb_ready = 1'b1;
      repeat (10) tick();
      // A second request while the fill is running must be ignored.
      clear_req = 1'b1; clear_color = 9'h1AA;
      tick();
      clear_req = 1'b0; clear_color = 9'h000;
      done_seen = 1'b0;
      for (int c = 0; c < 25000 && !done_seen; c++) begin
         tick();
         if (done_pulses > 0) done_seen = 1'b1;
      end
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL clear_timeout got done=%0b want 1", done_seen); end
      repeat (5) tick();
      checks++; if (wr_q.size() !== 19202) begin errors++; $display("FAIL clear_count got %0d want 19202", wr_q.size()); end
      if (wr_q.size() >= 2) begin
         checks++;
         if (wr_q[0] !== {15'd1127, 9'h1FF} || wr_q[1] !== {15'd1288, 9'h000}) begin
            errors++;
            $display("FAIL clear_pixels got %h %h want %h %h", wr_q[0], wr_q[1],
                     {15'd1127, 9'h1FF}, {15'd1288, 9'h000});
         end
      end
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < 19200 && (i + 2) < wr_q.size(); i++) begin
         if (wr_q[i+2] !== {15'(i), 9'h049}) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL clear_sequence got %0d bad writes (first at %0d: %h) want 0", bad, first_bad,
                  (first_bad >= 0) ? wr_q[first_bad+2] : 24'h0);
      end
      checks++; if (done_pulses !== 1) begin errors++; $display("FAIL clear_done_pulses got %0d want 1", done_pulses); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %0b want 0", busy); end
      $display("test_clear writes=%0d done_pulses=%0d", wr_q.size(), done_pulses);
   endtask

   task automatic test_reset_mid_clear();
      logic found;
      fb_ready = 1'b1;
      clear_req = 1'b1; clear_color = 9'h1FF;
      tick();
      clear_req = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         tick();
         if (fb_we === 1'b1 && fb_addr === 15'd1000) found = 1'b1;
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL rmc_reach1000 got %0b want 1", found); end
      resetn = 1'b0;
      #1;
      checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rmc_we got %0b want 0", fb_we); end
      checks++; if (fb_addr !== 15'd0) begin errors++; $display("FAIL rmc_addr got %0d want 0", fb_addr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got %0b want 0", busy); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmc_overflow got %0b want 0", overflow); end
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      wr_q.delete();
      done_pulses = 0;
      draw_enable = 1'b1; x_in = 8'd2; y_in = 8'd2; rgb_in = 24'h00FF00;   // 322, 038
      tick();
      draw_enable = 1'b0;
      repeat (4) tick();
      checks++;
      if (wr_q.size() !== 1 || wr_q[0] !== {15'd322, 9'h038}) begin
         errors++;
         $display("FAIL rmc_pixel got n=%0d first=%h want n=1 %h", wr_q.size(),
                  (wr_q.size() > 0) ? wr_q[0] : 24'h0, {15'd322, 9'h038});
      end
      checks++; if (done_pulses !== 0) begin errors++; $display("FAIL rmc_clear_done got %0d want 0", done_pulses); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_idle_busy got %0b want 0", busy); end
      $display("test_reset_mid_clear writes=%0d", wr_q.size());
   endtask

   initial begin
      test_reset();
      test_single();
      test_edge_pixel();
      test_stall();
      test_overflow();
      test_offscreen();
      test_clear();
      test_reset_mid_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
